// File: rtl/pow2_shift_div_pipe_if.sv
// Valid/ready bus for pow2_shift_div_pipe: operand/shift/mode in, result out.
// POW2_SHIFT_INEXACT_EN adds the out_inexact result flag.
interface pow2_shift_div_pipe_if #(
   parameter int unsigned N = 8
);
   localparam int unsigned SW = $clog2(N);

   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  in_data;
   logic [SW-1:0] in_shamt;
   logic [1:0]    in_mode;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  out_data;
`ifdef POW2_SHIFT_INEXACT_EN
   logic          out_inexact;

   modport master (
      output in_valid, in_data, in_shamt, in_mode, out_ready,
      input  in_ready, out_valid, out_data, out_inexact
   );
   modport slave (
      input  in_valid, in_data, in_shamt, in_mode, out_ready,
      output in_ready, out_valid, out_data, out_inexact
   );
`else
   modport master (
      output in_valid, in_data, in_shamt, in_mode, out_ready,
      input  in_ready, out_valid, out_data
   );
   modport slave (
      input  in_valid, in_data, in_shamt, in_mode, out_ready,
      output in_ready, out_valid, out_data
   );
`endif
endinterface

// File: rtl/pow2_shift_div_pipe.sv
// Pipelined right shifter: logical, arithmetic, or signed divide by 2^s (truncating).
// POW2_SHIFT_INEXACT_EN adds out_inexact (nonzero bits shifted out of the operand).
module pow2_shift_div_pipe #(
   parameter int unsigned N = 8
) (
   input logic                   clk,
   input logic                   rst_n,
   pow2_shift_div_pipe_if.slave  bus
);
   localparam int unsigned SW       = $clog2(N);
   localparam logic [1:0]  MODE_LOG = 2'b00;
   localparam logic [1:0]  MODE_DIV = 2'b10;

   logic          adv_c;
   logic [N-1:0]  mask_c;
   logic [N-1:0]  op_c;
   logic          big_c;
   logic          div_c;
   logic          inexact_c;

   logic          vld_q [0:SW];
   logic [N-1:0]  dat_q [0:SW];
   logic [SW-1:0] sh_q  [0:SW];
   logic          sgn_q [0:SW];
   logic          inx_q [0:SW];

   // Right shift by a constant amount with a chosen fill bit
   function automatic logic [N-1:0] shr(input logic [N-1:0] d, input int amt, input logic fill);
      logic [2*N-1:0] w;
      w = {{N{fill}}, d} >> amt;
      return w[N-1:0];
   endfunction

   assign adv_c        = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = adv_c;

   // Stage 0 operand prep: low-bit mask doubles as the divide bias and inexact mask
   always_comb begin
      mask_c = '0;
      for (int i = 0; i < int'(N); i++) begin
         mask_c[i] = (i < int'(bus.in_shamt));
      end
      big_c     = 32'(bus.in_shamt) >= N;
      div_c     = bus.in_mode == MODE_DIV;
      inexact_c = |(bus.in_data & mask_c);
      op_c      = bus.in_data;
      // A shift of N or more truncates every divide to zero; the bias would not fit
      if (div_c && big_c) begin
         op_c = '0;
      end else if (div_c && bus.in_data[N-1]) begin
         op_c = bus.in_data + mask_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k <= int'(SW); k++) begin
            vld_q[k] <= 1'b0;
            dat_q[k] <= '0;
            sh_q[k]  <= '0;
            sgn_q[k] <= 1'b0;
            inx_q[k] <= 1'b0;
         end
         bus.out_valid   <= 1'b0;
         bus.out_data    <= '0;
`ifdef POW2_SHIFT_INEXACT_EN
         bus.out_inexact <= 1'b0;
`endif
      end else if (adv_c) begin
         vld_q[0] <= bus.in_valid;
         dat_q[0] <= op_c;
         sh_q[0]  <= bus.in_shamt;
         sgn_q[0] <= bus.in_mode != MODE_LOG;
         inx_q[0] <= inexact_c;
         // Barrel stage k shifts by 2^(k-1); signed modes replicate the current MSB
         for (int k = 1; k <= int'(SW); k++) begin
            vld_q[k] <= vld_q[k-1];
            dat_q[k] <= sh_q[k-1][k-1]
                        ? shr(dat_q[k-1], 1 << (k-1), sgn_q[k-1] & dat_q[k-1][N-1])
                        : dat_q[k-1];
            sh_q[k]  <= sh_q[k-1];
            sgn_q[k] <= sgn_q[k-1];
            inx_q[k] <= inx_q[k-1];
         end
         bus.out_valid   <= vld_q[SW];
         bus.out_data    <= dat_q[SW];
`ifdef POW2_SHIFT_INEXACT_EN
         bus.out_inexact <= inx_q[SW];
`endif
      end
   end
endmodule

// File: doc/pow2_shift_div_pipe.md
# pow2_shift_div_pipe

Pipelined, run-time-configurable right shifter for N-bit words. Per transaction it performs a logical shift, an arithmetic shift (floor division by 2^s), or a signed divide by 2^s that truncates toward zero. Shift amount and mode vary per transaction. It sits between a valid/ready producer and consumer in the datapath and generalises the fixed-S arithmetic shifter into a backpressure-aware pipeline.

## Interface
- `N`, default 8: data width; N ≥ 2.
- `SW`, default `$clog2(N)`: shift-amount width; derived, not overridden.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  input transaction present.
- `in_ready`  out  1  block accepts input this cycle.
- `in_data`  in  N  operand `a`, two's complement.
- `in_shamt`  in  SW  shift amount `s`, unsigned.
- `in_mode`  in  2  operation: 00 logical, 01 arithmetic, 10 signed divide, 11 arithmetic.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts result.
- `out_data`  out  N  result.
- `out_inexact`  out  1  present only with `POW2_SHIFT_INEXACT_EN`.

## Operation
- Stage 0 registers the operand after optional bias, plus `s`, mode and flags.
  - Divide with `a` < 0: the bias 2^s − 1 is added to `a`. The sum cannot overflow N bits for s ≤ N−1.
  - All other cases use a bias of 0.
- Stages 1..SW are barrel stages. Stage k shifts by 2^(k−1) when `s[k−1]` = 1.
  - Fill bit is 0 for logical mode and the operand sign bit for arithmetic and divide modes.
- Required results:
  - Logical: `a >> s`.
  - Arithmetic: `a >>> s`.
  - Divide: trunc(a / 2^s).
- `s` ≥ N (reachable only when N is not a power of two):
  - logical → 0;
  - arithmetic → all bits = `a[N−1]`;
  - divide → 0.
- Flow control: a single global advance `adv = !out_valid || out_ready`.
  - Every stage loads from its predecessor when `adv` = 1 and holds otherwise.
  - `in_ready = adv`.
  - A transfer occurs on `in_valid && in_ready` and on `out_valid && out_ready`.
  - Bubbles are not collapsed.
- Each stage carries a valid bit. Transactions leave in acceptance order; none is dropped or duplicated.

## Timing
- Latency is SW+1 cycles from the input transfer edge to `out_valid` high, with no backpressure (N=8: 4 cycles).
- Throughput is one transaction per cycle while `out_ready` is held high.
- Reset (`rst_n` low, asynchronous) clears all stage valid bits, `out_valid` = 0, `out_data` = 0 and `out_inexact` = 0.
  - `in_ready` = 1 during and after reset.
  - In-flight transactions are discarded.
  - The first accept is possible on the first rising edge with `rst_n` high.
- While `out_valid` = 1 and `out_ready` = 0:
  - `out_data` and `out_inexact` hold stable;
  - all stages freeze;
  - `in_ready` = 0.
- Same-cycle input and output transfers are both honoured when `out_ready` = 1.
- `in_*` are sampled only on a transfer edge. Values during `in_valid` = 0 are don't-care.

## Configuration
- `POW2_SHIFT_INEXACT_EN` defined:
  - adds `out_inexact` = 1 iff any 1 bit of the original `a` was shifted out, i.e. `a & (2^s − 1)` ≠ 0, or `a` ≠ 0 when s ≥ N;
  - the flag is computed in stage 0 from the unbiased operand and travels with the transaction.
- Macro undefined: the port and its logic are absent, and all other behaviour is identical.

## Test plan
- N=8, `a`=0xF9 (−7), s=1, modes 00/01/10 back-to-back with `out_ready`=1 → 0x7C, 0xFC (−4), 0xFD (−3) on three consecutive cycles starting 4 cycles after the first accept; `out_inexact`=1 each.
- N=8, `a`=0x80 (−128), s=7, divide → 0xFF (−1), `out_inexact`=0. `a`=0x81, s=7, divide → 0x00, `out_inexact`=1.
- N=8, `a`=0x40, s=0, all modes → 0x40; `a`=0x7F, s=3, divide → 0x0F.
- Backpressure: 6 transactions streamed, `out_ready` low for 3 cycles after the first result → `out_data` held, `in_ready`=0 during the stall, all 6 results delivered in order, none lost or duplicated.
- Reset mid-flight: `rst_n` dropped with 3 transactions in the pipeline → `out_valid`=0 immediately and no stale result appears after release.
- N=6 (SW=3), s=6 and s=7, `a`=0x21 → logical 0x00, arithmetic 0x3F, divide 0x00, `out_inexact`=1.
